aes256_key_sched_ctrl: RTL and testbench
========================================

AES256_KEY_SCHED_CTRL -- requirements
Module: aes256_key_sched_ctrl

Interface
REQ-001 Parameter EXP_LATENCY, default 14, SHALL set the clock cycles from exp_key change to valid rk_bus; legal range 1..31.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 key_valid  input  1  new 256-bit cipher key offered.
REQ-005 key_ready  output  1  controller can accept a key.
REQ-006 key_in  input  256  cipher key, FIPS-197 byte order, MSB = byte 0.
REQ-007 key_clear  input  1  zeroize the stored key and return to IDLE.
REQ-008 exp_key  output  256  registered key driven to the key-expansion datapath.
REQ-009 rk_bus  input  1792  expansion outputs k1..k14 concatenated, k1 in bits [1791:1664], k14 in bits [127:0].
REQ-010 keys_ready  output  1  all round keys 0..14 valid.
REQ-011 rk_req  input  1  round-key read request, single-cycle strobe.
REQ-012 rk_idx  input  4  requested round index 0..14.
REQ-013 rk_valid  output  1  rk_out valid, one-cycle pulse.
REQ-014 rk_out  output  128  requested round key.
REQ-015 rk_err  output  1  one-cycle pulse: request rejected.

Function
REQ-016 The FSM SHALL have states IDLE, EXPAND and READY.
REQ-017 key_ready SHALL be 1 in IDLE and READY and 0 in EXPAND.
REQ-018 A key is accepted when key_valid and key_ready are both 1 on a rising edge: exp_key <= key_in, cycle counter <= 0, state <= EXPAND.
REQ-019 In EXPAND the counter SHALL increment each cycle; when it reaches EXP_LATENCY-1 the state goes to READY on the next edge, so keys_ready rises exactly EXP_LATENCY cycles after acceptance.
REQ-020 keys_ready SHALL be 1 only in READY and SHALL be a registered output.
REQ-021 Round key 0 SHALL be exp_key[255:128]; round key i (1..14) SHALL be the matching rk_bus slice.
REQ-022 rk_req in READY with rk_idx <= 14 SHALL produce rk_valid = 1 and rk_out = that round key on the next cycle; latency is 1.
REQ-023 rk_req with rk_idx > 14, or in IDLE/EXPAND, SHALL produce rk_err = 1 on the next cycle, with rk_valid = 0 and rk_out unchanged.
REQ-024 Key acceptance in READY, simultaneous with rk_req, SHALL serve the request from the current (old) keys; the state then enters EXPAND and keys_ready drops on the next cycle.
REQ-025 key_clear SHALL have priority over key acceptance and rk_req in any state: exp_key <= 0, state <= IDLE, rk_out <= 0, no rk_valid and no rk_err that cycle.
REQ-026 key_valid while key_ready = 0 SHALL be ignored; the source holds it until accepted.
REQ-027 rk_valid and rk_err SHALL never be 1 in the same cycle.

Reset
REQ-028 Asserting reset_n low SHALL immediately set the state to IDLE and zero exp_key, rk_out and the counter.
REQ-029 During reset, keys_ready, rk_valid and rk_err SHALL be 0, and key_ready SHALL be 0 while reset_n is low.
REQ-030 Reset during EXPAND SHALL abandon the expansion; no keys_ready may follow until a new key is accepted.

Structure
REQ-031 A shared package aes_pkg SHALL hold AES_NR = 14, KEY_W = 256, RK_W = 128 and the FSM state encoding.
REQ-032 The key-expansion datapath SHALL stay external and connect only via exp_key and rk_bus.
REQ-033 One sub-module, aes_rk_select, SHALL implement the combinational 15:1 round-key mux.

Verification
REQ-034 Load key 000102...1e1f and wait for keys_ready. Then read idx 0 -> 000102030405060708090a0b0c0d0e0f, idx 1 -> 101112131415161718191a1b1c1d1e1f, idx 14 -> 24fc79ccbf0979e9371ac23c6d68de36.
REQ-035 Count cycles from acceptance to the keys_ready rise -> exactly EXP_LATENCY (14). key_ready = 0 throughout EXPAND.
REQ-036 rk_idx = 15 in READY -> rk_err pulse, no rk_valid. Any rk_req during EXPAND -> rk_err pulse.
REQ-037 New key plus rk_req idx 14 in the same READY cycle -> old k14 returned; keys_ready low next cycle, then high 14 cycles later with the new keys.
REQ-038 Drop reset_n mid-EXPAND (cycle 7) -> immediate IDLE, outputs zero, keys_ready stays 0. key_clear in READY -> IDLE, exp_key = 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the AES-256 key schedule controller.
// Widths here size both the controller and the external expansion datapath.
package aes_pkg;
  localparam int AES_NR = 14;
  localparam int KEY_W  = 256;
  localparam int RK_W   = 128;
  localparam int RKB_W  = AES_NR * RK_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } ks_state_t;
endpackage

// File: rtl/aes_rk_select.sv
// Combinational 15:1 round-key mux: k0 from the cipher key, k1..k14 from rk_bus.
// Out-of-range indices yield zero; the controller rejects them anyway.
module aes_rk_select
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] i_exp_key,
  input  logic [RKB_W-1:0] i_rk_bus,
  input  logic [3:0]       i_idx,
  output logic [RK_W-1:0]  o_rk
);

  always_comb begin
    o_rk = '0;
    if (i_idx == 4'd0)
      o_rk = i_exp_key[KEY_W-1 -: RK_W];
    // k1 sits at the top of rk_bus, k14 at the bottom
    for (int i = 1; i <= AES_NR; i++) begin
      if (i_idx == 4'(i))
        o_rk = i_rk_bus[(AES_NR-i)*RK_W +: RK_W];
    end
  end

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key schedule controller: latches the cipher key, waits out the
// external expansion latency, then serves round-key reads with 1-cycle latency.
module aes256_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int EXP_LATENCY = 14
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_clear,
  output logic [KEY_W-1:0] exp_key,
  input  logic [RKB_W-1:0] rk_bus,
  output logic             keys_ready,
  input  logic             rk_req,
  input  logic [3:0]       rk_idx,
  output logic             rk_valid,
  output logic [RK_W-1:0]  rk_out,
  output logic             rk_err
);

  localparam logic [4:0] LAST = 5'(EXP_LATENCY - 1);

  ks_state_t        r_state;
  logic [4:0]       r_cnt;
  logic [KEY_W-1:0] r_exp_key;
  logic             r_keys_ready;
  logic             r_rk_valid;
  logic             r_rk_err;
  logic [RK_W-1:0]  r_rk_out;

  logic             w_accept;
  logic             w_rd_ok;
  logic [RK_W-1:0]  w_rk;

  aes_rk_select u_sel (
    .i_exp_key (r_exp_key),
    .i_rk_bus  (rk_bus),
    .i_idx     (rk_idx),
    .o_rk      (w_rk)
  );

  // key_ready must read 0 while reset is held, not just IDLE
  assign key_ready = reset_n & (r_state != ST_EXPAND);
  assign w_accept  = key_valid & key_ready;
  assign w_rd_ok   = rk_req & (r_state == ST_READY)
                   & (rk_idx <= 4'(AES_NR));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_exp_key    <= '0;
      r_keys_ready <= 1'b0;
      r_rk_valid   <= 1'b0;
      r_rk_err     <= 1'b0;
      r_rk_out     <= '0;
    end else if (key_clear) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_exp_key    <= '0;
      r_keys_ready <= 1'b0;
      r_rk_valid   <= 1'b0;
      r_rk_err     <= 1'b0;
      r_rk_out     <= '0;
    end else begin
      r_rk_valid <= w_rd_ok;
      r_rk_err   <= rk_req & ~w_rd_ok;
      if (w_rd_ok)
        r_rk_out <= w_rk;
      unique case (r_state)
        ST_IDLE, ST_READY: begin
          if (w_accept) begin
            r_exp_key    <= key_in;
            r_cnt        <= '0;
            r_state      <= ST_EXPAND;
            r_keys_ready <= 1'b0;
          end
        end
        ST_EXPAND: begin
          if (r_cnt == LAST) begin
            r_state      <= ST_READY;
            r_keys_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign exp_key    = r_exp_key;
  assign keys_ready = r_keys_ready;
  assign rk_valid   = r_rk_valid;
  assign rk_err     = r_rk_err;
  assign rk_out     = r_rk_out;

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Bench for aes256_key_sched_ctrl with a behavioural AES-256 key expansion
// standing in for the external datapath and serving as the reference model.
module tb_aes256_key_sched_ctrl;

  logic           clock = 1'b0;
  logic           reset_n = 1'b1;
  logic           key_valid = 1'b0;
  logic           key_ready;
  logic [255:0]   key_in = '0;
  logic           key_clear = 1'b0;
  logic [255:0]   exp_key;
  logic [1791:0]  rk_bus;
  logic           keys_ready;
  logic           rk_req = 1'b0;
  logic [3:0]     rk_idx = '0;
  logic           rk_valid;
  logic [127:0]   rk_out;
  logic           rk_err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  aes256_key_sched_ctrl #(.EXP_LATENCY(14)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .key_clear  (key_clear),
    .exp_key    (exp_key),
    .rk_bus     (rk_bus),
    .keys_ready (keys_ready),
    .rk_req     (rk_req),
    .rk_idx     (rk_idx),
    .rk_valid   (rk_valid),
    .rk_out     (rk_out),
    .rk_err     (rk_err)
  );

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(logic [7:0] x);
    logic [7:0] v = '0;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // All 15 round keys, k0 in the top 128 bits, k14 in the bottom
  function automatic logic [1919:0] expand_all(logic [255:0] key);
    logic [31:0]   w[60];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1919:0] all = '0;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++)
      all[(14-r)*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return all;
  endfunction

  function automatic logic [127:0] rk_of(logic [255:0] key, int idx);
    logic [1919:0] all = expand_all(key);
    return all[(14-idx)*128 +: 128];
  endfunction

  logic [1919:0] all_k;
  always_comb all_k = expand_all(exp_key);
  assign rk_bus = all_k[1791:0];

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [127:0] last_rk = '0;

  task automatic rd(input string tag, input logic [3:0] idx,
                    input logic [127:0] exp_rk);
    rk_req = 1'b1;
    rk_idx = idx;
    tick();
    rk_req = 1'b0;
    check({tag, "_valid"}, rk_valid, 1'b1);
    check({tag, "_err"}, rk_err, 1'b0);
    check({tag, "_data"}, rk_out, exp_rk);
    last_rk = exp_rk;
  endtask

  // Waits for keys_ready; optionally probes a read during EXPAND at cycle probe
  task automatic wait_ready(input int probe, output int cyc, output int bad);
    cyc = 0;
    bad = 0;
    while (keys_ready !== 1'b1 && cyc < 40) begin
      if (key_ready !== 1'b0) bad++;
      if (cyc == probe) begin
        rk_req = 1'b1;
        rk_idx = 4'($urandom_range(0, 14));
      end
      tick();
      cyc++;
      if (cyc == probe + 1) begin
        rk_req = 1'b0;
        check("expand_rk_err", rk_err, 1'b1);
        check("expand_rk_valid", rk_valid, 1'b0);
      end
    end
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [255:0] k0, k1, k2, model_key;
    int cyc, bad, seen;

    // reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_key_ready", key_ready, 1'b0);
    check("rst_keys_ready", keys_ready, 1'b0);
    check("rst_rk_valid", rk_valid, 1'b0);
    check("rst_rk_err", rk_err, 1'b0);
    check("rst_exp_key", exp_key, '0);
    check("rst_rk_out", rk_out, '0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    check("idle_key_ready", key_ready, 1'b1);

    // FIPS-197 AES-256 vector
    k0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    key_in = k0;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    model_key = k0;
    check("load_exp_key", exp_key, k0);
    wait_ready(-1, cyc, bad);
    check("latency", cyc, 14);
    check("expand_key_ready", bad, 0);
    check("keys_ready_hi", keys_ready, 1'b1);
    check("ready_key_ready", key_ready, 1'b1);
    rd("vec_k0", 4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    rd("vec_k1", 4'd1, 128'h101112131415161718191a1b1c1d1e1f);
    rd("vec_k14", 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // out-of-range index
    rk_req = 1'b1;
    rk_idx = 4'd15;
    tick();
    rk_req = 1'b0;
    check("idx15_err", rk_err, 1'b1);
    check("idx15_valid", rk_valid, 1'b0);
    check("idx15_hold", rk_out, last_rk);
    tick();
    check("err_pulse", rk_err, 1'b0);

    // new key together with a read of the old k14
    k1 = rand_key();
    key_in = k1;
    key_valid = 1'b1;
    rk_req = 1'b1;
    rk_idx = 4'd14;
    tick();
    key_valid = 1'b0;
    rk_req = 1'b0;
    check("swap_valid", rk_valid, 1'b1);
    check("swap_old_k14", rk_out, rk_of(model_key, 14));
    check("swap_keys_ready", keys_ready, 1'b0);
    model_key = k1;
    last_rk = rk_of(model_key, 14);
    wait_ready(3, cyc, bad);
    check("latency2", cyc, 14);
    check("expand_key_ready2", bad, 0);
    for (int n = 0; n < 8; n++) begin
      int idx;
      idx = $urandom_range(0, 14);
      rd("rand_rd", 4'(idx), rk_of(model_key, idx));
    end

    // reset in the middle of EXPAND
    k2 = rand_key();
    key_in = k2;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    for (int n = 0; n < 7; n++) tick();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_key_ready", key_ready, 1'b0);
    check("midrst_keys_ready", keys_ready, 1'b0);
    check("midrst_exp_key", exp_key, '0);
    check("midrst_rk_out", rk_out, '0);
    tick();
    reset_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (keys_ready !== 1'b0) seen++;
    end
    check("midrst_no_ready", seen, 0);
    check("midrst_idle", key_ready, 1'b1);

    // key_clear beats acceptance and reads in READY
    key_in = k2;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    model_key = k2;
    wait_ready(-1, cyc, bad);
    check("latency3", cyc, 14);
    rd("k2_rd", 4'd7, rk_of(model_key, 7));
    key_clear = 1'b1;
    key_valid = 1'b1;
    key_in = rand_key();
    rk_req = 1'b1;
    rk_idx = 4'd3;
    tick();
    key_clear = 1'b0;
    key_valid = 1'b0;
    rk_req = 1'b0;
    check("clr_exp_key", exp_key, '0);
    check("clr_rk_out", rk_out, '0);
    check("clr_rk_valid", rk_valid, 1'b0);
    check("clr_rk_err", rk_err, 1'b0);
    check("clr_keys_ready", keys_ready, 1'b0);
    check("clr_key_ready", key_ready, 1'b1);
    tick();
    check("clr_stays_idle", keys_ready, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
